// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALU control codes, muldiv FSM state encoding and
//            operation-class helpers.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU multiply/divide control codes
    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_MULHU  = 3'b011;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_DIVU   = 3'b101;
    localparam logic [2:0] c_OP_REM    = 3'b110;
    localparam logic [2:0] c_OP_REMU   = 3'b111;

    // Iterative unit state encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Divide or remainder operation
    function automatic logic f_is_div(input logic [2:0] op);
        return (op == c_OP_DIV) || (op == c_OP_DIVU) ||
               (op == c_OP_REM) || (op == c_OP_REMU);
    endfunction

    // Operand A is interpreted as two's complement
    function automatic logic f_a_signed(input logic [2:0] op);
        return (op == c_OP_MULH) || (op == c_OP_MULHSU) ||
               (op == c_OP_DIV)  || (op == c_OP_REM);
    endfunction

    // Operand B is interpreted as two's complement
    function automatic logic f_b_signed(input logic [2:0] op);
        return (op == c_OP_MULH) || (op == c_OP_DIV) || (op == c_OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Brief    : One combinational iteration of a radix-2 shift-add multiply or
//            a restoring shift-subtract divide on unsigned magnitudes.
//            The accumulator is {i_hi, i_lo}.
//            Multiply : i_lo holds the multiplier, i_opnd the multiplicand.
//            Divide   : i_lo holds the dividend/quotient, i_hi the partial
//                       remainder, i_opnd the divisor.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Single iteration: add-then-shift-right, or shift-left-then-trial-subtract
    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});
        w_shift = {i_hi, i_lo[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, i_opnd});
        // When the trial succeeds the true difference is below the divisor,
        // so the low WIDTH bits are exact.
        w_diff  = w_shift[WIDTH-1:0] - i_opnd;
        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
            o_lo = {i_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Brief    : Iterative multiply/divide unit. WIDTH-cycle shift-add multiply
//            and restoring divide on magnitudes with sign pre/post
//            correction; divide-by-zero and signed overflow finish in one
//            cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] DATA_A,
    input  logic [WIDTH-1:0] DATA_B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] OUT,
    output logic             N,
    output logic             Z,
    output logic             DZ
);

    localparam int               c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_neg_p;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_out;
    logic             r_dz;

    logic [1:0]         w_state_next;
    logic               w_accept;
    logic               w_a_sgn;
    logic               w_b_sgn;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_fast;
    logic [WIDTH-1:0]   w_fast_res;
    logic [WIDTH-1:0]   w_hi_n;
    logic [WIDTH-1:0]   w_lo_n;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_c;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res;

    assign busy = (r_state == c_ST_CALC);
    assign done = (r_state == c_ST_DONE);
    assign OUT  = r_out;
    assign DZ   = r_dz;
    assign N    = r_out[WIDTH-1];
    assign Z    = (r_out == '0);

    // Operand decode at accept: magnitudes, signs and fast-path detection
    always_comb begin
        w_accept   = start && (r_state != c_ST_CALC);
        w_a_sgn    = f_a_signed(op) && DATA_A[WIDTH-1];
        w_b_sgn    = f_b_signed(op) && DATA_B[WIDTH-1];
        w_mag_a    = w_a_sgn ? -DATA_A : DATA_A;
        w_mag_b    = w_b_sgn ? -DATA_B : DATA_B;
        w_b_zero   = (DATA_B == '0);
        w_ovf      = ((op == c_OP_DIV) || (op == c_OP_REM)) &&
                     (DATA_A == c_MIN) && (DATA_B == c_ONES);
        w_fast     = f_is_div(op) && (w_b_zero || w_ovf);
        // op[1] distinguishes remainder from quotient among the divide codes
        if (w_b_zero) begin
            w_fast_res = op[1] ? DATA_A : c_ONES;
        end else begin
            w_fast_res = op[1] ? '0 : c_MIN;
        end
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (f_is_div(r_op)),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_hi_n),
        .o_lo     (w_lo_n)
    );

    // Sign post-correction and result select from the final iteration
    always_comb begin
        w_prod   = {w_hi_n, w_lo_n};
        w_prod_c = r_neg_p ? -w_prod : w_prod;
        w_quo    = r_neg_p ? -w_lo_n : w_lo_n;
        w_rem    = r_neg_r ? -w_hi_n : w_hi_n;
        case (r_op)
            c_OP_MUL:                        w_res = w_prod_c[WIDTH-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_res = w_prod_c[2*WIDTH-1:WIDTH];
            c_OP_DIV, c_OP_DIVU:             w_res = w_quo;
            default:                         w_res = w_rem;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (w_accept) begin
                    w_state_next = w_fast ? c_ST_DONE : c_ST_CALC;
                end else begin
                    w_state_next = c_ST_IDLE;
                end
            end
            c_ST_CALC: begin
                if (r_cnt == c_LAST) begin
                    w_state_next = c_ST_DONE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // State, operand latch, iteration datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_op    <= c_OP_MUL;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_neg_p <= 1'b0;
            r_neg_r <= 1'b0;
            r_out   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op    <= op;
                r_cnt   <= '0;
                r_hi    <= '0;
                r_neg_p <= w_a_sgn ^ w_b_sgn;
                r_neg_r <= w_a_sgn;
                if (f_is_div(op)) begin
                    r_lo   <= w_mag_a;
                    r_opnd <= w_mag_b;
                end else begin
                    r_lo   <= w_mag_b;
                    r_opnd <= w_mag_a;
                end
                if (w_fast) begin
                    r_out <= w_fast_res;
                    r_dz  <= w_b_zero;
                end
            end else if (r_state == c_ST_CALC) begin
                r_hi  <= w_hi_n;
                r_lo  <= w_lo_n;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    r_cnt <= '0;
                    r_out <= w_res;
                    r_dz  <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv
// Brief    : Directed table-driven bench for alu_muldiv (WIDTH = 32) with
//            hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

    localparam int W = 32;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic         dz;
        int           lat;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] DATA_A = '0;
    logic [W-1:0] DATA_B = '0;
    logic         busy, done, N, Z, DZ;
    logic [W-1:0] OUT;

    int n_tests = 0;
    int n_fail  = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .DATA_A(DATA_A), .DATA_B(DATA_B),
        .busy(busy), .done(done), .OUT(OUT), .N(N), .Z(Z), .DZ(DZ)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op with a single-cycle start pulse; return edges-to-done
    // (accepting edge counts as 1) and the number of busy cycles seen.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; op = o; DATA_A = a; DATA_B = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1; nbusy = 0;
        while (!done && lat < 100) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t vecs[22];

    initial begin
        int lat, nb;
        string nm;

        vecs[0]  = '{MUL,    32'd7,        32'd6,        32'd42,       1'b0, 33};
        vecs[1]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33};
        vecs[2]  = '{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33};
        vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, 33};
        vecs[4]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33};
        vecs[5]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33};
        vecs[6]  = '{DIVU,   32'd100,      32'd7,        32'd14,       1'b0, 33};
        vecs[7]  = '{REMU,   32'd100,      32'd7,        32'd2,        1'b0, 33};
        vecs[8]  = '{DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1};
        vecs[9]  = '{REM,    32'd5,        32'd0,        32'd5,        1'b1, 1};
        vecs[10] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
        vecs[11] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1};
        vecs[12] = '{DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1};
        vecs[13] = '{REMU,   32'd5,        32'd0,        32'd5,        1'b1, 1};
        vecs[14] = '{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33};
        vecs[15] = '{MUL,    32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 33};
        vecs[16] = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33};
        vecs[17] = '{DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33};
        vecs[18] = '{REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
        vecs[19] = '{DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 33};
        vecs[20] = '{REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
        vecs[21] = '{MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_out",  OUT, 32'd0);
        check("reset_dz",   {31'd0, DZ}, 32'd0);
        check("reset_z",    {31'd0, Z}, 32'd1);
        reset = 1'b0;

        // Table of directed vectors
        for (int i = 0; i < 22; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nb);
            nm = $sformatf("vec%0d", i);
            check({nm, "_out"},  OUT, vecs[i].out);
            check({nm, "_dz"},   {31'd0, DZ}, {31'd0, vecs[i].dz});
            check({nm, "_n"},    {31'd0, N}, {31'd0, vecs[i].out[W-1]});
            check({nm, "_z"},    {31'd0, Z}, {31'd0, (vecs[i].out == '0)});
            check({nm, "_lat"},  lat, vecs[i].lat);
            check({nm, "_busy"}, nb, (vecs[i].lat == 1) ? 0 : 32);
        end

        // start held high through CALC with operands changing: one op only
        @(negedge clk);
        start = 1'b1; op = MUL; DATA_A = 32'd3; DATA_B = 32'd5;
        @(posedge clk);
        @(negedge clk);
        DATA_A = 32'd100; DATA_B = 32'd100;
        lat = 1; nb = 0;
        while (!done && lat < 100) begin
            if (busy) nb++;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("hold_out",  OUT, 32'd15);
        check("hold_busy", nb, 32);
        @(negedge clk);
        check("hold_idle_busy", {31'd0, busy}, 32'd0);
        check("hold_idle_done", {31'd0, done}, 32'd0);

        // Back-to-back: start during DONE starts the next op with no bubble
        run_op(MUL, 32'd2, 32'd3, lat, nb);
        check("b2b_first_out", OUT, 32'd6);
        start = 1'b1; op = DIVU; DATA_A = 32'd100; DATA_B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_bubble", {31'd0, busy}, 32'd1);
        check("b2b_out_held",  OUT, 32'd6);
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_second_out", OUT, 32'd14);
        check("b2b_second_lat", lat, 33);
        repeat (3) @(negedge clk);
        check("idle_hold_out", OUT, 32'd14);

        // Reset mid-divide discards the op and clears OUT/DZ immediately
        run_op(DIV, 32'd5, 32'd0, lat, nb);
        check("pre_reset_dz", {31'd0, DZ}, 32'd1);
        @(negedge clk);
        start = 1'b1; op = DIV; DATA_A = 32'd100; DATA_B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_done", {31'd0, done}, 32'd0);
        check("mid_reset_out",  OUT, 32'd0);
        check("mid_reset_dz",   {31'd0, DZ}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(MUL, 32'd3, 32'd3, lat, nb);
        check("post_reset_out", OUT, 32'd9);
        check("post_reset_lat", lat, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; even, >= 4.
REQ-002 Port: clk  input  1  rising-edge clock; single clock domain.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request pulse; sampled on a rising edge of clk.
REQ-005 Port: op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: DATA_A  input  WIDTH  operand A (multiplicand/dividend).
REQ-007 Port: DATA_B  input  WIDTH  operand B (multiplier/divisor).
REQ-008 Port: busy  output  1  high while an operation is iterating.
REQ-009 Port: done  output  1  one-cycle pulse; OUT is valid.
REQ-010 Port: OUT  output  WIDTH  registered result.
REQ-011 Port: N  output  1  OUT[WIDTH-1], combinational from OUT.
REQ-012 Port: Z  output  1  high when OUT is all zeros, combinational from OUT.
REQ-013 Port: DZ  output  1  registered; high when the last completed op was a divide/remainder with DATA_B == 0.

Function
REQ-014 States: IDLE, CALC, DONE; busy = (state == CALC); done = (state == DONE).
REQ-015 start is accepted in IDLE or DONE; it is ignored in CALC, and operands are not re-sampled while busy.
REQ-016 On accept, op, DATA_A and DATA_B are latched; the next state is CALC, except on fast-path cases, which go to DONE.
REQ-017 CALC runs exactly WIDTH iterations via an iteration counter, then moves to DONE.
REQ-018 Latency: done is high in the cycle following the (WIDTH+1)th rising edge after the accepting edge; a fast path gives done in the cycle following the 1st edge.
REQ-019 DONE lasts one cycle, then IDLE unless a new start is accepted, in which case back-to-back operation occurs with no bubble.
REQ-020 Multiply is radix-2 shift-add on 2*WIDTH-bit magnitudes: MUL returns low WIDTH bits; MULH returns high bits signed x signed; MULHSU signed A x unsigned B; MULHU unsigned x unsigned.
REQ-021 Divide is restoring, on magnitudes.
REQ-021a Quotient sign = sign(A) XOR sign(B), signed ops only.
REQ-021b Remainder sign = sign(A).
REQ-021c Quotient truncates toward zero.
REQ-022 Divide by zero (fast path): DIV/DIVU give all ones; REM/REMU give DATA_A; DZ = 1.
REQ-023 Signed overflow (fast path): DIV of the most-negative value by -1 gives the most-negative value; REM gives 0; DZ = 0.
REQ-024 OUT and DZ update only on the edge entering DONE; they hold otherwise, including across IDLE.
REQ-025 All arithmetic is modulo 2^WIDTH on OUT; no carry/overflow flag is produced.

Reset
REQ-026 reset asserted (any time, including mid-CALC): state = IDLE; OUT = 0; DZ = 0; counter = 0; busy = 0; done = 0. The in-flight operation is discarded.
REQ-027 The first start after reset deassertion is accepted on the first rising edge at which start = 1.

Structure
REQ-028 Shared package alu_pkg holds the op encodings (localparams) and the state encoding; the existing ALU control codes are unchanged.
REQ-029 One sub-module, muldiv_step, is natural: a combinational single-iteration shift-add/shift-subtract step; alu_muldiv holds the FSM, counter, and sign pre/post-correction.
REQ-030 No latches; all state is in one always block clocked on posedge clk or posedge reset.

Verification (WIDTH=32)
REQ-031 MUL 7 x 6, start for one cycle -> busy for 32 cycles, done at the 33rd cycle, OUT=42, N=0, Z=0.
REQ-032 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> OUT=0xFFFFFFFE; MULH with the same operands -> OUT=0; MULHSU 0xFFFFFFFF x 2 -> OUT=0xFFFFFFFF.
REQ-033 DIV -7 / 2 -> OUT=0xFFFFFFFD (-3), N=1; REM -7 / 2 -> OUT=0xFFFFFFFF (-1); DIVU 100 / 7 -> 14; REMU -> 2.
REQ-034 DIV 5 / 0 -> done one cycle after accept, OUT=0xFFFFFFFF, DZ=1; REM 5 / 0 -> OUT=5; DIV 0x80000000 / 0xFFFFFFFF -> OUT=0x80000000, DZ=0; REM of the same -> OUT=0, Z=1.
REQ-035 start held high throughout CALC -> a single operation only; start during DONE -> the next op begins with no idle cycle.
REQ-036 reset pulse at iteration 10 of a DIV -> busy=0, OUT=0 immediately; a following MUL 3 x 3 -> OUT=9 with normal latency.
